// File: rtl/cluster_mem_port_if.sv
// Cluster request bus and DRAM line bus of cluster_mem_port.
// The master modport is the requester/DRAM side; the slave modport is the port itself.
interface cluster_mem_port_if;
  logic         w_re;
  logic         w_we;
  logic [31:0]  w_addr;
  logic [2:0]   w_ctrl;
  logic [31:0]  w_wdata;
  logic         w_flush;
  logic         w_dram_busy;
  logic [127:0] w_dram_rdata;
  logic         r_dram_req;
  logic         r_dram_we;
  logic [31:0]  r_dram_addr;
  logic [127:0] r_dram_wdata;
  logic [15:0]  r_dram_mask;
  logic         w_busy;
  logic [127:0] r_line;
  logic [31:0]  r_rdata;
  logic         r_err;

  modport master (
    output w_re, w_we, w_addr, w_ctrl, w_wdata, w_flush, w_dram_busy, w_dram_rdata,
    input  r_dram_req, r_dram_we, r_dram_addr, r_dram_wdata, r_dram_mask,
    input  w_busy, r_line, r_rdata, r_err
  );

  modport slave (
    input  w_re, w_we, w_addr, w_ctrl, w_wdata, w_flush, w_dram_busy, w_dram_rdata,
    output r_dram_req, r_dram_we, r_dram_addr, r_dram_wdata, r_dram_mask,
    output w_busy, r_line, r_rdata, r_err
  );
endinterface

// File: rtl/cluster_mem_port.sv
// Cluster-to-DRAM line port: one access at a time, byte/half/word extraction and store lanes.
// Optional one-line read buffer enabled with the CLUSTER_LINEBUF_EN macro.
module cluster_mem_port #(
  parameter int WAIT_MAX = 1023
) (
  input logic               CLK,
  input logic               RST_X,
  cluster_mem_port_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [9:0] WDOG_LIMIT = 10'(WAIT_MAX);

  logic [1:0]   state_r;
  logic [3:0]   off_r;
  logic [2:0]   ctrl_r;
  logic [9:0]   wdog_r;
  logic         dram_req_r;
  logic         dram_we_r;
  logic         err_r;
  logic [31:0]  dram_addr_r;
  logic [31:0]  rdata_r;
  logic [127:0] dram_wdata_r;
  logic [127:0] line_r;
  logic [15:0]  dram_mask_r;
  logic         req_s;
  logic         misalign_s;
  logic         hit_s;
  logic         wdog_exp_s;

  // ctrl[1:0] gives the size; the undefined encodings 011/110/111 fall into the word case.
  function automatic logic misaligned_f(input logic [2:0] ctrl, input logic [1:0] a);
    logic bad;
    case (ctrl[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = a[0];
      default: bad = (a != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] extract_f(input logic [127:0] line, input logic [3:0] a,
                                            input logic [2:0] ctrl);
    logic [31:0] word_v;
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [31:0] res;
    word_v = line[{a[3:2], 5'b00000} +: 32];
    half_v = word_v[{a[1], 4'b0000} +: 16];
    byte_v = half_v[{a[0], 3'b000} +: 8];
    case (ctrl)
      3'b000:  res = {{24{byte_v[7]}}, byte_v};
      3'b001:  res = {{16{half_v[15]}}, half_v};
      3'b100:  res = {24'h000000, byte_v};
      3'b101:  res = {16'h0000, half_v};
      default: res = word_v;
    endcase
    return res;
  endfunction

  function automatic logic [15:0] mask_f(input logic [2:0] ctrl, input logic [3:0] a);
    logic [15:0] m;
    case (ctrl[1:0])
      2'b00:   m = 16'h0001 << a;
      2'b01:   m = 16'h0003 << a;
      default: m = 16'h000F << a;
    endcase
    return m;
  endfunction

  function automatic logic [127:0] lanes_f(input logic [2:0] ctrl, input logic [31:0] d);
    logic [127:0] v;
    case (ctrl[1:0])
      2'b00:   v = {16{d[7:0]}};
      2'b01:   v = {8{d[15:0]}};
      default: v = {4{d}};
    endcase
    return v;
  endfunction

  // Request decode and watchdog expiry shared by the FSM and the line buffer.
  always_comb begin
    req_s      = bus.w_re | bus.w_we;
    misalign_s = misaligned_f(bus.w_ctrl, bus.w_addr[1:0]);
    wdog_exp_s = ((wdog_r + 10'd1) == WDOG_LIMIT);
  end

`ifdef CLUSTER_LINEBUF_EN
  logic [27:0] tag_r;
  logic        valid_r;

  // A read to the buffered line skips DRAM unless a flush lands in the same cycle.
  always_comb begin
    hit_s = bus.w_re && !bus.w_we && !bus.w_flush && valid_r && (tag_r == bus.w_addr[31:4]);
  end

  // Tag/valid mirror r_line; flushes, conflicting writes and aborts drop the entry.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      tag_r   <= 28'h0000000;
      valid_r <= 1'b0;
    end else if (bus.w_flush) begin
      valid_r <= 1'b0;
    end else if ((state_r == ST_IDLE) && bus.w_we && (tag_r == bus.w_addr[31:4])) begin
      valid_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && !bus.w_dram_busy && !dram_we_r) begin
      tag_r   <= dram_addr_r[31:4];
      valid_r <= 1'b1;
    end else if ((state_r == ST_WAIT) && wdog_exp_s) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end
`else
  logic unused_s;

  // Without the buffer every aligned read goes to DRAM and flush is ignored.
  always_comb begin
    hit_s = 1'b0;
  end
  assign unused_s = bus.w_flush;
`endif

  // Access sequencer: IDLE -> ISSUE -> WAIT -> DONE, with early exits to DONE.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_r      <= ST_IDLE;
      off_r        <= 4'h0;
      ctrl_r       <= 3'b000;
      wdog_r       <= 10'd0;
      dram_req_r   <= 1'b0;
      dram_we_r    <= 1'b0;
      err_r        <= 1'b0;
      dram_addr_r  <= 32'h0000_0000;
      rdata_r      <= 32'h0000_0000;
      dram_wdata_r <= 128'h0;
      line_r       <= 128'h0;
      dram_mask_r  <= 16'h0000;
    end else begin
      dram_req_r <= 1'b0;
      err_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            off_r  <= bus.w_addr[3:0];
            ctrl_r <= bus.w_ctrl;
            if (misalign_s) begin
              state_r <= ST_DONE;
              err_r   <= 1'b1;
              rdata_r <= 32'h0000_0000;
            end else if (hit_s) begin
              state_r <= ST_DONE;
              rdata_r <= extract_f(line_r, bus.w_addr[3:0], bus.w_ctrl);
            end else begin
              state_r      <= ST_ISSUE;
              dram_req_r   <= 1'b1;
              dram_we_r    <= bus.w_we;
              dram_addr_r  <= {bus.w_addr[31:4], 4'h0};
              dram_wdata_r <= lanes_f(bus.w_ctrl, bus.w_wdata);
              dram_mask_r  <= bus.w_we ? mask_f(bus.w_ctrl, bus.w_addr[3:0]) : 16'h0000;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
          wdog_r  <= 10'd0;
        end
        ST_WAIT: begin
          if (!bus.w_dram_busy) begin
            state_r <= ST_DONE;
            if (!dram_we_r) begin
              line_r  <= bus.w_dram_rdata;
              rdata_r <= extract_f(bus.w_dram_rdata, off_r, ctrl_r);
            end
          end else if (wdog_exp_s) begin
            state_r <= ST_DONE;
            err_r   <= 1'b1;
          end else begin
            wdog_r <= wdog_r + 10'd1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.w_busy       = ((state_r == ST_IDLE) && req_s) || (state_r == ST_ISSUE) ||
                            (state_r == ST_WAIT);
  assign bus.r_dram_req   = dram_req_r;
  assign bus.r_dram_we    = dram_we_r;
  assign bus.r_dram_addr  = dram_addr_r;
  assign bus.r_dram_wdata = dram_wdata_r;
  assign bus.r_dram_mask  = dram_mask_r;
  assign bus.r_line       = line_r;
  assign bus.r_rdata      = rdata_r;
  assign bus.r_err        = err_r;

endmodule
